// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video RAM between the VGA fetcher (always wins)
// and the CPU bus (reads in free slots, writes posted through a 1-entry buffer).
module vram_arbiter #(
   parameter int ADDR_WIDTH  = 13,
   parameter int DATA_WIDTH  = 8,
   parameter int STALL_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   vid_req,
   input  logic [ADDR_WIDTH-1:0]  vid_addr,
   output logic                   vid_rvalid,
   output logic [DATA_WIDTH-1:0]  vid_rdata,
   input  logic                   cpu_valid,
   input  logic                   cpu_we,
   input  logic [ADDR_WIDTH-1:0]  cpu_addr,
   input  logic [DATA_WIDTH-1:0]  cpu_wdata,
   output logic                   cpu_ready,
   output logic                   cpu_rvalid,
   output logic [DATA_WIDTH-1:0]  cpu_rdata,
   output logic                   ram_en,
   output logic                   ram_we,
   output logic [ADDR_WIDTH-1:0]  ram_addr,
   output logic [DATA_WIDTH-1:0]  ram_wdata,
   input  logic [DATA_WIDTH-1:0]  ram_rdata,
   input  logic                   stats_clr,
   output logic [STALL_WIDTH-1:0] cpu_stall_cycles
);

   typedef enum logic [1:0] {TAG_IDLE, TAG_VID, TAG_CPU} tag_e;

   logic                   ramEn_q, ramEn_d, ramWe_q, ramWe_d;
   logic [ADDR_WIDTH-1:0]  ramAddr_q, ramAddr_d;
   logic [DATA_WIDTH-1:0]  ramWdata_q, ramWdata_d;
   logic                   wbValid_q, wbValid_d;
   logic [ADDR_WIDTH-1:0]  wbAddr_q, wbAddr_d;
   logic [DATA_WIDTH-1:0]  wbData_q, wbData_d;
   tag_e                   tag1_q, tag1_d, tag2_q;
   logic                   fwd1_q, fwd1_d, fwd2_q;
   logic [DATA_WIDTH-1:0]  fwdData1_q, fwdData1_d, fwdData2_q;
   logic                   vidRvalid_q, vidRvalid_d, cpuRvalid_q, cpuRvalid_d;
   logic [DATA_WIDTH-1:0]  vidRdata_q, vidRdata_d, cpuRdata_q, cpuRdata_d;
   logic [STALL_WIDTH-1:0] stallCnt_q, stallCnt_d;
   logic                   cpuRead, drain, acceptRd, acceptWr;

   // A pending CPU read blocks the drain so reads never wait behind posted writes.
   always_comb begin
      cpuRead   = cpu_valid && !cpu_we;
      drain     = wbValid_q && !vid_req && !cpuRead;
      cpu_ready = cpu_we ? (!wbValid_q || drain) : !vid_req;
      acceptRd  = cpuRead && cpu_ready;
      acceptWr  = cpu_valid && cpu_we && cpu_ready;
   end

   always_comb begin
      ramEn_d    = 1'b0;
      ramWe_d    = 1'b0;
      ramAddr_d  = ramAddr_q;
      ramWdata_d = ramWdata_q;
      tag1_d     = TAG_IDLE;
      fwd1_d     = 1'b0;
      fwdData1_d = wbData_q;
      wbValid_d  = wbValid_q;
      wbAddr_d   = wbAddr_q;
      wbData_d   = wbData_q;
      if (vid_req) begin
         ramEn_d   = 1'b1;
         ramAddr_d = vid_addr;
         tag1_d    = TAG_VID;
      end else if (acceptRd) begin
         ramEn_d   = 1'b1;
         ramAddr_d = cpu_addr;
         tag1_d    = TAG_CPU;
         fwd1_d    = wbValid_q && (wbAddr_q == cpu_addr);
      end else if (drain) begin
         ramEn_d    = 1'b1;
         ramWe_d    = 1'b1;
         ramAddr_d  = wbAddr_q;
         ramWdata_d = wbData_q;
      end
      if (drain)
         wbValid_d = 1'b0;
      if (acceptWr) begin
         wbValid_d = 1'b1;
         wbAddr_d  = cpu_addr;
         wbData_d  = cpu_wdata;
      end
   end

   // Result steering: the tag two stages behind the command selects the port.
   always_comb begin
      vidRvalid_d = (tag2_q == TAG_VID);
      vidRdata_d  = vidRdata_q;
      cpuRvalid_d = (tag2_q == TAG_CPU);
      cpuRdata_d  = cpuRdata_q;
      if (tag2_q == TAG_VID)
         vidRdata_d = ram_rdata;
      if (tag2_q == TAG_CPU)
         cpuRdata_d = fwd2_q ? fwdData2_q : ram_rdata;
      stallCnt_d = stallCnt_q;
      if (stats_clr)
         stallCnt_d = '0;
      else if (cpu_valid && !cpu_ready && (stallCnt_q != '1))
         stallCnt_d = stallCnt_q + STALL_WIDTH'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ramEn_q     <= 1'b0;
         ramWe_q     <= 1'b0;
         ramAddr_q   <= '0;
         ramWdata_q  <= '0;
         wbValid_q   <= 1'b0;
         wbAddr_q    <= '0;
         wbData_q    <= '0;
         tag1_q      <= TAG_IDLE;
         tag2_q      <= TAG_IDLE;
         fwd1_q      <= 1'b0;
         fwd2_q      <= 1'b0;
         fwdData1_q  <= '0;
         fwdData2_q  <= '0;
         vidRvalid_q <= 1'b0;
         vidRdata_q  <= '0;
         cpuRvalid_q <= 1'b0;
         cpuRdata_q  <= '0;
         stallCnt_q  <= '0;
      end else begin
         ramEn_q     <= ramEn_d;
         ramWe_q     <= ramWe_d;
         ramAddr_q   <= ramAddr_d;
         ramWdata_q  <= ramWdata_d;
         wbValid_q   <= wbValid_d;
         wbAddr_q    <= wbAddr_d;
         wbData_q    <= wbData_d;
         tag1_q      <= tag1_d;
         tag2_q      <= tag1_q;
         fwd1_q      <= fwd1_d;
         fwd2_q      <= fwd1_q;
         fwdData1_q  <= fwdData1_d;
         fwdData2_q  <= fwdData1_q;
         vidRvalid_q <= vidRvalid_d;
         vidRdata_q  <= vidRdata_d;
         cpuRvalid_q <= cpuRvalid_d;
         cpuRdata_q  <= cpuRdata_d;
         stallCnt_q  <= stallCnt_d;
      end
   end

   assign ram_en           = ramEn_q;
   assign ram_we           = ramWe_q;
   assign ram_addr         = ramAddr_q;
   assign ram_wdata        = ramWdata_q;
   assign vid_rvalid       = vidRvalid_q;
   assign vid_rdata        = vidRdata_q;
   assign cpu_rvalid       = cpuRvalid_q;
   assign cpu_rdata        = cpuRdata_q;
   assign cpu_stall_cycles = stallCnt_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model (architectural memory, due-time result queues).
module tb_vram_arbiter;

   logic        clk, rst_n;
   logic        vid_req, vid_rvalid;
   logic [12:0] vid_addr;
   logic [7:0]  vid_rdata;
   logic        cpu_valid, cpu_we, cpu_ready, cpu_rvalid;
   logic [12:0] cpu_addr;
   logic [7:0]  cpu_wdata, cpu_rdata;
   logic        ram_en, ram_we;
   logic [12:0] ram_addr;
   logic [7:0]  ram_wdata, ram_rdata;
   logic        stats_clr;
   logic [3:0]  cpu_stall_cycles;

   vram_arbiter #(.ADDR_WIDTH(13), .DATA_WIDTH(8), .STALL_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ready(cpu_ready), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .stats_clr(stats_clr), .cpu_stall_cycles(cpu_stall_cycles)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] mem  [0:8191];
   logic [7:0] arch [0:8191];

   // Synchronous-read single-port RAM attached to the arbiter's command port.
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         else        ram_rdata <= mem[ram_addr];
      end
   end

   typedef struct {int due; logic [7:0] data;} res_t;
   res_t        vidQ[$];
   res_t        cpuQ[$];
   int          compared, mismatched, edgeCnt, mCnt;
   logic        mWbV, expEn, expWe, accepted;
   logic [12:0] mWbA, expAddr;
   logic [7:0]  mWbD, expWdata;

   function automatic logic [7:0] pat(input logic [12:0] a);
      return a[7:0] + 8'h10;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ram_en"}, {31'd0, ram_en}, 0);
      checkOutput({tag, "_ram_we"}, {31'd0, ram_we}, 0);
      checkOutput({tag, "_ram_addr"}, {19'd0, ram_addr}, 0);
      checkOutput({tag, "_ram_wdata"}, {24'd0, ram_wdata}, 0);
      checkOutput({tag, "_vid_rvalid"}, {31'd0, vid_rvalid}, 0);
      checkOutput({tag, "_vid_rdata"}, {24'd0, vid_rdata}, 0);
      checkOutput({tag, "_cpu_rvalid"}, {31'd0, cpu_rvalid}, 0);
      checkOutput({tag, "_cpu_rdata"}, {24'd0, cpu_rdata}, 0);
      checkOutput({tag, "_stall"}, {28'd0, cpu_stall_cycles}, 0);
      checkOutput({tag, "_cpu_ready"}, {31'd0, cpu_ready}, 1);
   endtask

   // One clock: check what the last edge produced, predict the next edge, advance.
   task automatic applyStimulus();
      logic hit, cpuRd, drain, expReady;
      @(negedge clk);
      checkOutput("ram_en", {31'd0, ram_en}, {31'd0, expEn});
      if (expEn) begin
         checkOutput("ram_we", {31'd0, ram_we}, {31'd0, expWe});
         checkOutput("ram_addr", {19'd0, ram_addr}, {19'd0, expAddr});
         if (expWe) checkOutput("ram_wdata", {24'd0, ram_wdata}, {24'd0, expWdata});
      end
      hit = (vidQ.size() > 0) && (vidQ[0].due == edgeCnt);
      checkOutput("vid_rvalid", {31'd0, vid_rvalid}, {31'd0, hit});
      if (hit) begin
         checkOutput("vid_rdata", {24'd0, vid_rdata}, {24'd0, vidQ[0].data});
         void'(vidQ.pop_front());
      end
      hit = (cpuQ.size() > 0) && (cpuQ[0].due == edgeCnt);
      checkOutput("cpu_rvalid", {31'd0, cpu_rvalid}, {31'd0, hit});
      if (hit) begin
         checkOutput("cpu_rdata", {24'd0, cpu_rdata}, {24'd0, cpuQ[0].data});
         void'(cpuQ.pop_front());
      end
      checkOutput("stall_cnt", {28'd0, cpu_stall_cycles}, mCnt);

      cpuRd    = cpu_valid && !cpu_we;
      drain    = mWbV && !vid_req && !cpuRd;
      expReady = cpu_we ? (!mWbV || drain) : !vid_req;
      if (cpu_valid) checkOutput("cpu_ready", {31'd0, cpu_ready}, {31'd0, expReady});
      accepted = cpu_valid && expReady;
      if (stats_clr) mCnt = 0;
      else if (cpu_valid && !expReady && mCnt < 15) mCnt++;
      expEn = 1'b0;
      expWe = 1'b0;
      if (vid_req) begin
         expEn = 1'b1; expAddr = vid_addr;
         vidQ.push_back('{due: edgeCnt + 3, data: pat(vid_addr)});
      end else if (cpuRd && expReady) begin
         expEn = 1'b1; expAddr = cpu_addr;
         cpuQ.push_back('{due: edgeCnt + 3, data: arch[cpu_addr]});
      end else if (drain) begin
         expEn = 1'b1; expWe = 1'b1; expAddr = mWbA; expWdata = mWbD;
      end
      if (drain) mWbV = 1'b0;
      if (cpu_valid && cpu_we && expReady) begin
         mWbV = 1'b1; mWbA = cpu_addr; mWbD = cpu_wdata;
         arch[cpu_addr] = cpu_wdata;
      end
      @(posedge clk);
      edgeCnt++;
      #1;
   endtask

   task automatic cpuReq(input logic we, input logic [12:0] a, input logic [7:0] d);
      cpu_valid = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
   endtask

   initial begin
      compared = 0; mismatched = 0; edgeCnt = 0; mCnt = 0;
      mWbV = 1'b0; expEn = 1'b0; expWe = 1'b0; accepted = 1'b0;
      mWbA = '0; mWbD = '0; expAddr = '0; expWdata = '0;
      for (int a = 0; a < 8192; a++) begin
         mem[a]  = pat(13'(a));
         arch[a] = pat(13'(a));
      end
      vid_req = 0; vid_addr = 0; cpu_valid = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
      stats_clr = 0;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #1 checkResetOutputs("reset");
      #20;
      @(posedge clk); #1 rst_n = 1'b1;

      $display("[TB] video streaming");
      for (int i = 0; i < 8; i++) begin
         vid_req = 1'b1; vid_addr = 13'(i);
         applyStimulus();
      end
      vid_req = 1'b0;
      repeat (4) applyStimulus();

      $display("[TB] contention");
      cpuReq(1'b0, 13'h100, 8'h00);
      for (int i = 0; i < 4; i++) begin
         vid_req = 1'b1; vid_addr = 13'(8'h20 + i);
         applyStimulus();
      end
      vid_req = 1'b0;
      applyStimulus();
      cpu_valid = 1'b0;
      checkOutput("contention_stall", {28'd0, cpu_stall_cycles}, 4);
      repeat (4) applyStimulus();

      $display("[TB] forwarding");
      vid_req = 1'b1; vid_addr = 13'h40;
      cpuReq(1'b1, 13'h200, 8'hAB);
      applyStimulus();
      cpuReq(1'b0, 13'h200, 8'h00);
      for (int i = 0; i < 3; i++) begin
         vid_addr = 13'(8'h41 + i);
         applyStimulus();
      end
      vid_req = 1'b0;
      applyStimulus();
      cpu_valid = 1'b0;
      repeat (5) applyStimulus();
      checkOutput("fwd_ram_written", {24'd0, mem[13'h200]}, 32'hAB);

      $display("[TB] buffer full");
      vid_req = 1'b1; vid_addr = 13'h50;
      cpuReq(1'b1, 13'h201, 8'h11);
      applyStimulus();
      cpuReq(1'b1, 13'h202, 8'h22);
      repeat (3) applyStimulus();
      vid_req = 1'b0;
      applyStimulus();
      cpu_valid = 1'b0;
      repeat (4) applyStimulus();
      checkOutput("buffull_first", {24'd0, mem[13'h201]}, 32'h11);
      checkOutput("buffull_second", {24'd0, mem[13'h202]}, 32'h22);

      $display("[TB] saturation and clear");
      stats_clr = 1'b1;
      applyStimulus();
      stats_clr = 1'b0;
      vid_req = 1'b1; vid_addr = 13'h60;
      cpuReq(1'b0, 13'h101, 8'h00);
      repeat (20) applyStimulus();
      checkOutput("stall_saturated", {28'd0, cpu_stall_cycles}, 15);
      stats_clr = 1'b1;
      applyStimulus();
      checkOutput("stall_cleared", {28'd0, cpu_stall_cycles}, 0);
      stats_clr = 1'b0; vid_req = 1'b0;
      applyStimulus();
      cpu_valid = 1'b0;
      repeat (4) applyStimulus();

      $display("[TB] reset mid-read");
      vid_req = 1'b1; vid_addr = 13'h70;
      cpuReq(1'b1, 13'h300, 8'h5A);
      applyStimulus();
      vid_req = 1'b0;
      cpuReq(1'b0, 13'h104, 8'h00);
      applyStimulus();
      cpu_valid = 1'b0; cpu_we = 1'b0;
      #2 rst_n = 1'b0;
      #1 checkResetOutputs("midreset");
      vidQ.delete(); cpuQ.delete();
      mWbV = 1'b0; mCnt = 0; expEn = 1'b0; expWe = 1'b0;
      arch[13'h300] = pat(13'h300);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (6) applyStimulus();
      checkOutput("dropped_write", {24'd0, mem[13'h300]}, {24'd0, pat(13'h300)});

      $display("[TB] random traffic");
      for (int i = 0; i < 400; i++) begin
         vid_req   = ($urandom_range(0, 99) < 45);
         vid_addr  = 13'($urandom_range(0, 255));
         stats_clr = ($urandom_range(0, 49) == 0);
         if (!cpu_valid && $urandom_range(0, 99) < 60)
            cpuReq(1'($urandom_range(0, 1)), 13'h100 + 13'($urandom_range(0, 7)), 8'($urandom));
         applyStimulus();
         if (accepted) cpu_valid = 1'b0;
      end
      vid_req = 1'b0; cpu_valid = 1'b0; stats_clr = 1'b0;
      repeat (6) applyStimulus();
      checkOutput("vid_results_left", vidQ.size(), 0);
      checkOutput("cpu_results_left", cpuQ.size(), 0);
      for (int a = 'h100; a < 'h108; a++)
         checkOutput("final_mem", {24'd0, mem[a]}, {24'd0, arch[a]});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Shares the single-port, synchronous-read video RAM between the VGA scan-out fetcher and the CPU bus inside `puter`. Video fetches always win and see a fixed latency. CPU reads are served in free slots. CPU writes are posted through a one-entry write buffer with read forwarding. A saturating counter records CPU stall cycles for debug.

## Interface
Parameters:
- `ADDR_WIDTH`, 13, VRAM word address width
- `DATA_WIDTH`, 8, VRAM word width
- `STALL_WIDTH`, 16, stall counter width

Ports:
- `clk` in 1: single clock, the VGA pixel domain.
- `rst_n` in 1: reset, asynchronous and active-low.
- `vid_req` in 1, `vid_addr` in ADDR_WIDTH: video fetch request, one word per asserted cycle.
- `vid_rvalid` out 1, `vid_rdata` out DATA_WIDTH: video fetch result.
- `cpu_valid` in 1, `cpu_we` in 1, `cpu_addr` in ADDR_WIDTH, `cpu_wdata` in DATA_WIDTH: CPU request. Held stable until accepted.
- `cpu_ready` out 1: combinational accept. A transfer occurs on a rising edge with `cpu_valid && cpu_ready`.
- `cpu_rvalid` out 1, `cpu_rdata` out DATA_WIDTH: CPU read result.
- `ram_en` out 1, `ram_we` out 1, `ram_addr` out ADDR_WIDTH, `ram_wdata` out DATA_WIDTH: registered RAM command.
- `ram_rdata` in DATA_WIDTH: valid in the cycle after an `ram_en && !ram_we` command.
- `stats_clr` in 1: synchronous clear of the stall counter.
- `cpu_stall_cycles` out STALL_WIDTH: saturating count of stall cycles.

## Operation
- The RAM slot for cycle N+1 is decided at edge N. Priority: `vid_req` > accepted CPU read > write-buffer drain.
- **Write buffer**: holds one entry (`wb_valid`, `wb_addr`, `wb_data`).
  - Drain condition: `wb_valid && !vid_req && !(cpu_valid && !cpu_we)`.
  - A drain issues `ram_en=ram_we=1` with the buffered address and data.
- **cpu_ready**:
  - Read: `!vid_req`.
  - Write: `!wb_valid || drain`.
  - An accepted write loads the buffer, and `wb_valid=1` from the next cycle.
  - A write accepted on the same edge as a drain reloads the buffer. Nothing is lost.
- **Read forwarding**: if a read is accepted while `wb_valid && wb_addr==cpu_addr`:
  - The read still issues a RAM read.
  - The returned data is replaced by `wb_data`, captured at accept.
  - Latency is unchanged.
- **Result tagging**: a 2-stage tag pipeline (idle/video/cpu, plus a forward flag and forward data) follows each RAM command. Results are steered to exactly one port.
- **Stall counter**: increments each cycle with `cpu_valid && !cpu_ready` and saturates at all-ones. `stats_clr` takes priority over increment.
- **Ordering**: CPU requests complete in program order. A write that follows a read to the same address never affects that read's data.

## Timing
- **Reset values**:
  - All `ram_*` outputs, `vid_rvalid`, `vid_rdata`, `cpu_rvalid`, `cpu_rdata`, `wb_valid` and `cpu_stall_cycles` are 0.
  - `cpu_ready` evaluates combinationally from inputs.
- **Video latency**: `vid_req` sampled at edge N gives RAM command in N+1, `ram_rdata` in N+2, registered `vid_rvalid` in N+3.
  - The video port is never stalled.
  - Back-to-back requests yield back-to-back results.
- **CPU read latency**: accepted at edge N gives `cpu_rvalid` in N+3 for one cycle.
- **CPU write**: accepted at edge N sets `wb_valid` at N+1. The earliest drain decision is at edge N+1, giving the RAM write in N+2.
- Reads may be accepted every cycle with no video contention.
- **Continuous `vid_req`**:
  - CPU reads stall indefinitely.
  - Exactly one write is accepted, then writes stall until a free slot.
- **Simultaneous events**: a free slot with a CPU read pending and `wb_valid` goes to the read. A drain waits.
- **Reset mid-operation** (`rst_n` low asynchronously):
  - Pending results are discarded. No `rvalid` follows reset release.
  - Any buffered write is dropped.

## Test plan
- Video streaming: `vid_req` high with addresses 0..7 on consecutive cycles, RAM model holding `mem[a]=a+0x10` -> `vid_rvalid` high for 8 cycles starting 3 edges after the first request, data 0x10..0x17.
- Contention: CPU read of 0x100 held during 4 cycles of `vid_req` -> `cpu_ready` low for 4 cycles, accept on the 5th, `cpu_rvalid` 3 cycles later with `mem[0x100]`, `cpu_stall_cycles=4`.
- Forwarding: CPU write 0x200←0xAB with `vid_req` high continuously, then a read of 0x200 -> read blocked while video holds the slot. After video stops, read returns 0xAB and the RAM write occurs afterwards.
- Buffer full: `vid_req` high, two CPU writes back-to-back -> first accepted, second `cpu_ready=0` until `vid_req` drops. RAM then sees both writes in order.
- Saturation/clear: with `STALL_WIDTH=4`, 20 stalled cycles -> counter holds 15. `stats_clr` -> 0 next cycle.
- Reset mid-read: accept a CPU read, assert `rst_n` low at N+1 -> no `cpu_rvalid`, all outputs 0, `wb_valid` cleared.
